// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: schedules the single data-memory port between committed
// stores (buffered in a small circular store buffer) and issued loads.
// Loads win by default. A store is forced when the buffer is full or after
// STARVE_MAX back-to-back load grants with stores pending. A load whose byte
// range overlaps any buffered store is held until that store has drained.
//
// Optional build macro: MEM_ARB_PERF_EN adds the two performance counters.
// When it is undefined, both perf ports are tied to zero.

module mem_port_arbiter #(
   parameter int SB_DEPTH   = 4,
   parameter int STARVE_MAX = 3,
   parameter int PREG_W     = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   // committed stores from the LSQ
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [31:0]       st_addr,
   input  logic [31:0]       st_data,
   input  logic              st_sh,
   // issued loads
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [31:0]       ld_addr,
   input  logic [2:0]        ld_func3,
   input  logic [PREG_W-1:0] ld_pd,
   input  logic [4:0]        ld_rob_tag,
   // memory store port
   output logic              store_wb,
   output logic [31:0]       mem_st_addr,
   output logic [31:0]       mem_st_data,
   output logic              mem_st_sh,
   // memory load port
   output logic              load_mem,
   output logic [31:0]       mem_ld_addr,
   output logic [2:0]        mem_ld_func3,
   output logic [PREG_W-1:0] mem_ld_pd,
   output logic [4:0]        mem_ld_rob_tag,
   // status
   output logic              sb_empty,
   output logic [31:0]       perf_conflict_stalls,
   output logic [31:0]       perf_forced_stores
);

   localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

   localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_DEPTH);
   localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_MAX);

   localparam logic [2:0] FUNC3_LBU = 3'b100;

   // Byte-range overlap test. The ends are formed in 33 bits so that an
   // access ending exactly at 2^32 does not wrap to a small address.
   function automatic logic ranges_overlap(
      input logic [31:0] a_addr,
      input logic [2:0]  a_len,
      input logic [31:0] b_addr,
      input logic [2:0]  b_len
   );
      logic [32:0] a_lo, a_hi, b_lo, b_hi;
      a_lo = {1'b0, a_addr};
      a_hi = a_lo + {30'd0, a_len};
      b_lo = {1'b0, b_addr};
      b_hi = b_lo + {30'd0, b_len};
      return (a_lo < b_hi) && (b_lo < a_hi);
   endfunction

   // ------------------------------------------------------------------
   // Store buffer state
   // ------------------------------------------------------------------
   logic [31:0]       sb_addr [SB_DEPTH];
   logic [31:0]       sb_data [SB_DEPTH];
   logic              sb_sh   [SB_DEPTH];
   logic [SB_DEPTH-1:0] sb_vld;
   logic [PTR_W-1:0]  sb_head;
   logic [PTR_W-1:0]  sb_tail;
   logic [CNT_W-1:0]  sb_count;

   logic [STV_W-1:0]  starve;

   // ------------------------------------------------------------------
   // Per-cycle decision signals
   // ------------------------------------------------------------------
   logic       conflict;
   logic       force_store;
   logic       ld_accept;
   logic       st_push;
   logic       st_grant;
   logic [2:0] ld_len;
   logic       load_mem_q;

   // Load byte-range overlap against every valid buffered store.
   always_comb begin
      conflict = 1'b0;
      ld_len   = (ld_func3 == FUNC3_LBU) ? 3'd1 : 3'd4;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_vld[i] &&
             ranges_overlap(ld_addr, ld_len, sb_addr[i], sb_sh[i] ? 3'd2 : 3'd4)) begin
            conflict = 1'b1;
         end
      end
   end

   // Port arbitration: loads first unless a store is forced or the load conflicts.
   always_comb begin
      force_store = (sb_count == SB_FULL) || (starve == STV_LIM);
      ld_accept   = ld_valid && !conflict && !force_store && !flush;
      st_grant    = !ld_accept && (sb_count != '0);
      st_push     = st_valid && st_ready;
   end

   assign st_ready = (sb_count != SB_FULL);
   assign ld_ready = ld_accept;
   assign sb_empty = (sb_count == '0);

   // Store buffer payload write on push.
   // NOTE: payload arrays carry no reset; sb_vld alone says which entries are live.
   always_ff @(posedge clk) begin
      if (st_push) begin
         sb_addr[sb_tail] <= st_addr;
         sb_data[sb_tail] <= st_data;
         sb_sh[sb_tail]   <= st_sh;
      end
   end

   // Store buffer pointers, occupancy and per-entry valid bits.
   // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sb_head  <= '0;
         sb_tail  <= '0;
         sb_count <= '0;
         sb_vld   <= '0;
      end else begin
         // Push and pop never target the same slot: a pop needs count != 0
         // and a push needs count != SB_DEPTH, so head == tail excludes one.
         if (st_grant) begin
            sb_vld[sb_head] <= 1'b0;
            sb_head         <= sb_head + PTR_W'(1);
         end
         if (st_push) begin
            sb_vld[sb_tail] <= 1'b1;
            sb_tail         <= sb_tail + PTR_W'(1);
         end
         case ({st_push, st_grant})
            2'b10:   sb_count <= sb_count + CNT_W'(1);
            2'b01:   sb_count <= sb_count - CNT_W'(1);
            default: sb_count <= sb_count;
         endcase
      end
   end

   // Starvation counter: consecutive load grants while stores are waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve <= '0;
      end else if (ld_accept) begin
         if (sb_count == '0) begin
            starve <= '0;
         end else if (starve != STV_LIM) begin
            starve <= starve + STV_W'(1);
         end
      end else if (st_grant) begin
         starve <= '0;
      end
   end

   // Registered store-side memory interface.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         store_wb    <= 1'b0;
         mem_st_addr <= '0;
         mem_st_data <= '0;
         mem_st_sh   <= 1'b0;
      end else begin
         store_wb <= st_grant;
         if (st_grant) begin
            mem_st_addr <= sb_addr[sb_head];
            mem_st_data <= sb_data[sb_head];
            mem_st_sh   <= sb_sh[sb_head];
         end
      end
   end

   // Registered load-side memory interface.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_mem_q     <= 1'b0;
         mem_ld_addr    <= '0;
         mem_ld_func3   <= '0;
         mem_ld_pd      <= '0;
         mem_ld_rob_tag <= '0;
      end else begin
         load_mem_q <= ld_accept;
         if (ld_accept) begin
            mem_ld_addr    <= ld_addr;
            mem_ld_func3   <= ld_func3;
            mem_ld_pd      <= ld_pd;
            mem_ld_rob_tag <= ld_rob_tag;
         end
      end
   end

   // A flush squashes the load already on its way to memory; stores are
   // committed state and are never squashed.
   assign load_mem = load_mem_q && !flush;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] conflict_stalls_q;
   logic [31:0] forced_stores_q;

   // Performance counters, free-running and wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conflict_stalls_q <= '0;
         forced_stores_q   <= '0;
      end else begin
         if (ld_valid && conflict) begin
            conflict_stalls_q <= conflict_stalls_q + 32'd1;
         end
         if (st_grant && force_store && ld_valid && !conflict) begin
            forced_stores_q <= forced_stores_q + 32'd1;
         end
      end
   end

   assign perf_conflict_stalls = conflict_stalls_q;
   assign perf_forced_stores   = forced_stores_q;
`else
   assign perf_conflict_stalls = '0;
   assign perf_forced_stores   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
// Inputs change 1 ns after each rising edge; outputs are compared at that
// point, well away from the next active edge.

module tb_mem_port_arbiter;

   localparam int PREG_W = 7;

   logic              clk;
   logic              reset_n;
   logic              flush;
   logic              st_valid;
   logic              st_ready;
   logic [31:0]       st_addr;
   logic [31:0]       st_data;
   logic              st_sh;
   logic              ld_valid;
   logic              ld_ready;
   logic [31:0]       ld_addr;
   logic [2:0]        ld_func3;
   logic [PREG_W-1:0] ld_pd;
   logic [4:0]        ld_rob_tag;
   logic              store_wb;
   logic [31:0]       mem_st_addr;
   logic [31:0]       mem_st_data;
   logic              mem_st_sh;
   logic              load_mem;
   logic [31:0]       mem_ld_addr;
   logic [2:0]        mem_ld_func3;
   logic [PREG_W-1:0] mem_ld_pd;
   logic [4:0]        mem_ld_rob_tag;
   logic              sb_empty;
   logic [31:0]       perf_conflict_stalls;
   logic [31:0]       perf_forced_stores;

   int vectors     = 0;
   int miscompares = 0;
   int exp_stalls  = 0;
   int exp_forced  = 0;

   mem_port_arbiter #(
      .SB_DEPTH  (4),
      .STARVE_MAX(3),
      .PREG_W    (PREG_W)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .flush               (flush),
      .st_valid            (st_valid),
      .st_ready            (st_ready),
      .st_addr             (st_addr),
      .st_data             (st_data),
      .st_sh               (st_sh),
      .ld_valid            (ld_valid),
      .ld_ready            (ld_ready),
      .ld_addr             (ld_addr),
      .ld_func3            (ld_func3),
      .ld_pd               (ld_pd),
      .ld_rob_tag          (ld_rob_tag),
      .store_wb            (store_wb),
      .mem_st_addr         (mem_st_addr),
      .mem_st_data         (mem_st_data),
      .mem_st_sh           (mem_st_sh),
      .load_mem            (load_mem),
      .mem_ld_addr         (mem_ld_addr),
      .mem_ld_func3        (mem_ld_func3),
      .mem_ld_pd           (mem_ld_pd),
      .mem_ld_rob_tag      (mem_ld_rob_tag),
      .sb_empty            (sb_empty),
      .perf_conflict_stalls(perf_conflict_stalls),
      .perf_forced_stores  (perf_forced_stores)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      flush      = 1'b0;
      st_valid   = 1'b0;
      st_addr    = '0;
      st_data    = '0;
      st_sh      = 1'b0;
      ld_valid   = 1'b0;
      ld_addr    = '0;
      ld_func3   = '0;
      ld_pd      = '0;
      ld_rob_tag = '0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic sh);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_sh    = sh;
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] f3,
                       input logic [PREG_W-1:0] pd, input logic [4:0] tag);
      ld_valid   = 1'b1;
      ld_addr    = a;
      ld_func3   = f3;
      ld_pd      = pd;
      ld_rob_tag = tag;
   endtask

   // Watchdog: the directed sequence is a few hundred ns long.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench did not finish");
   end

   initial begin
      // ---------------- reset with random inputs ----------------
      idle();
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         flush    = 1'($urandom_range(0, 1));
         st_valid = 1'($urandom_range(0, 1));
         st_addr  = $urandom;
         st_data  = $urandom;
         st_sh    = 1'($urandom_range(0, 1));
         ld_valid = 1'($urandom_range(0, 1));
         ld_addr  = $urandom;
         ld_func3 = 3'($urandom_range(0, 7));
         tick();
         check("in_reset_store_wb", store_wb, 0);
         check("in_reset_load_mem", load_mem, 0);
         check("in_reset_sb_empty", sb_empty, 1);
      end
      idle();
      reset_n = 1'b1;
      settle();
      check("rst_store_wb", store_wb, 0);
      check("rst_load_mem", load_mem, 0);
      check("rst_st_ready", st_ready, 1);
      check("rst_sb_empty", sb_empty, 1);
      check("rst_mem_st_addr", mem_st_addr, 0);
      check("rst_mem_ld_addr", mem_ld_addr, 0);
      check("rst_perf_stalls", perf_conflict_stalls, 0);
      check("rst_perf_forced", perf_forced_stores, 0);

      // ---------------- load priority and starvation ----------------
      tick();
      push(32'h100, 32'hDEAD_BEEF, 1'b0);
      settle();
      check("prio_st_ready", st_ready, 1);
      tick();
      st_valid = 1'b0;
      load(32'h200, 3'b010, 7'd5, 5'd3);
      settle();
      check("prio_sb_not_empty", sb_empty, 0);
      check("prio_ld_ready0", ld_ready, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("prio_load_mem%0d", k), load_mem, 1);
         check($sformatf("prio_no_store%0d", k), store_wb, 0);
         check($sformatf("prio_ld_ready_after%0d", k), ld_ready, (k < 2) ? 1 : 0);
      end
      exp_forced++;
      tick();
      check("prio_store_wb", store_wb, 1);
      check("prio_store_addr", mem_st_addr, 32'h100);
      check("prio_store_data", mem_st_data, 32'hDEAD_BEEF);
      check("prio_store_sh", mem_st_sh, 0);
      check("prio_no_load", load_mem, 0);
      check("prio_ld_ready_resume", ld_ready, 1);
      check("prio_sb_empty", sb_empty, 1);
      tick();
      check("prio_load_resume", load_mem, 1);
      check("prio_ld_pd", mem_ld_pd, 5);
      check("prio_ld_tag", mem_ld_rob_tag, 3);
      check("prio_ld_func3", mem_ld_func3, 3'b010);
      check("prio_resume_no_store", store_wb, 0);
      ld_valid = 1'b0;
      tick();
      check("prio_idle", load_mem, 0);

      // ---------------- overlap hold: sh 0x103 vs lbu 0x104 ----------------
      push(32'h103, 32'h0000_BEEF, 1'b1);
      tick();
      st_valid = 1'b0;
      load(32'h104, 3'b100, 7'd9, 5'd7);
      settle();
      check("ovl_hold_ready", ld_ready, 0);
      exp_stalls++;
      tick();
      check("ovl_store_wb", store_wb, 1);
      check("ovl_store_addr", mem_st_addr, 32'h103);
      check("ovl_store_sh", mem_st_sh, 1);
      check("ovl_ready_at_wb", ld_ready, 1);
      tick();
      check("ovl_load_mem", load_mem, 1);
      check("ovl_load_addr", mem_ld_addr, 32'h104);
      check("ovl_load_func3", mem_ld_func3, 3'b100);
      ld_valid = 1'b0;
      tick();

      // ---------------- adjacent, no overlap: sh 0x103 vs lbu 0x105 ----------------
      push(32'h103, 32'h0000_1234, 1'b1);
      tick();
      st_valid = 1'b0;
      load(32'h105, 3'b100, 7'd10, 5'd8);
      settle();
      check("adj_ready", ld_ready, 1);
      tick();
      check("adj_load_mem", load_mem, 1);
      check("adj_no_store", store_wb, 0);
      ld_valid = 1'b0;
      tick();
      check("adj_store_wb", store_wb, 1);
      tick();
      check("adj_sb_empty", sb_empty, 1);

      // ---------------- top-of-space range must not wrap ----------------
      push(32'hFFFF_FFFC, 32'h5555_AAAA, 1'b0);
      tick();
      st_valid = 1'b0;
      load(32'hFFFF_FFFF, 3'b100, 7'd11, 5'd9);
      settle();
      check("wrap_hold_ready", ld_ready, 0);
      exp_stalls++;
      tick();
      check("wrap_store_wb", store_wb, 1);
      check("wrap_store_addr", mem_st_addr, 32'hFFFF_FFFC);
      check("wrap_ready_after", ld_ready, 1);
      ld_valid = 1'b0;
      tick();

      // ---------------- unknown func3 is a 4-byte access ----------------
      push(32'h702, 32'h0000_00AB, 1'b1);
      tick();
      st_valid = 1'b0;
      load(32'h700, 3'b000, 7'd12, 5'd10);
      settle();
      check("f3_other_hold", ld_ready, 0);
      exp_stalls++;
      tick();
      check("f3_other_store_wb", store_wb, 1);
      ld_valid = 1'b0;
      tick();

      // ---------------- full buffer ----------------
      load(32'h2000, 3'b010, 7'd1, 5'd1);
      for (int k = 0; k < 4; k++) begin
         push(32'h1000 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0);
         settle();
         check($sformatf("full_st_ready%0d", k), st_ready, 1);
         check($sformatf("full_ld_ready%0d", k), ld_ready, 1);
         tick();
      end
      push(32'h1010, 32'hA4, 1'b0);
      settle();
      check("full_st_ready_5th", st_ready, 0);
      check("full_ld_blocked", ld_ready, 0);
      check("full_load_mem_prev", load_mem, 1);
      exp_forced++;
      tick();
      st_valid = 1'b0;
      check("full_store_first", store_wb, 1);
      check("full_store_data0", mem_st_data, 32'hA0);
      check("full_no_load", load_mem, 0);
      check("full_ld_ready_after", ld_ready, 1);
      check("full_st_ready_after", st_ready, 1);
      tick();
      check("full_load_granted", load_mem, 1);
      check("full_no_store", store_wb, 0);
      ld_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         tick();
         check($sformatf("full_drain_wb%0d", k), store_wb, 1);
         check($sformatf("full_drain_data%0d", k), mem_st_data, 32'hA0 + 32'(k));
      end
      tick();
      check("full_5th_not_pushed", store_wb, 0);
      check("full_sb_empty", sb_empty, 1);

      // ---------------- flush squashes an issued load ----------------
      push(32'h500, 32'h1234_5678, 1'b0);
      tick();
      st_valid = 1'b0;
      load(32'h600, 3'b010, 7'd2, 5'd4);
      settle();
      check("flush_pre_ready", ld_ready, 1);
      tick();
      flush = 1'b1;
      settle();
      check("flush_kills_load_mem", load_mem, 0);
      check("flush_blocks_ld_ready", ld_ready, 0);
      tick();
      flush    = 1'b0;
      ld_valid = 1'b0;
      settle();
      check("flush_store_drains", store_wb, 1);
      check("flush_store_addr", mem_st_addr, 32'h500);
      check("flush_store_data", mem_st_data, 32'h1234_5678);
      check("flush_no_load", load_mem, 0);
      tick();
      check("flush_sb_empty", sb_empty, 1);

      // ---------------- three-cycle conflict stall ----------------
      load(32'h2000, 3'b010, 7'd3, 5'd5);
      push(32'h300, 32'hC0, 1'b0);
      tick();
      push(32'h304, 32'hC1, 1'b0);
      tick();
      push(32'h103, 32'hC2, 1'b1);
      tick();
      st_valid = 1'b0;
      load(32'h104, 3'b100, 7'd4, 5'd6);
      settle();
      check("stall_ready_c0", ld_ready, 0);
      tick();
      check("stall_wb_a", mem_st_addr, 32'h300);
      check("stall_ready_c1", ld_ready, 0);
      tick();
      check("stall_wb_b", mem_st_addr, 32'h304);
      check("stall_ready_c2", ld_ready, 0);
      tick();
      check("stall_wb_c", mem_st_addr, 32'h103);
      check("stall_wb_c_strobe", store_wb, 1);
      check("stall_ready_released", ld_ready, 1);
      exp_stalls += 3;
      tick();
      check("stall_load_mem", load_mem, 1);
      check("stall_load_addr", mem_ld_addr, 32'h104);
      ld_valid = 1'b0;
      tick();
      check("stall_sb_empty", sb_empty, 1);

      // ---------------- performance counters ----------------
`ifdef MEM_ARB_PERF_EN
      check("perf_conflict_stalls", perf_conflict_stalls, 64'(exp_stalls));
      check("perf_forced_stores", perf_forced_stores, 64'(exp_forced));
`else
      check("perf_conflict_tied", perf_conflict_stalls, 0);
      check("perf_forced_tied", perf_forced_stores, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
